bus_fill_arbiter: RTL and testbench
===================================

Name: bus_fill_arbiter

Overview:
Shares the single system-bus request/response channel between two block-fill requesters: port 0 (instruction fetch) and port 1 (data cache). It grants one requester at a time and drives the bus request handshake. It then steers the NUM_BEATS-beat response burst back to the owner one beat at a time. One outstanding transaction; sits between the fetch/data fill engines and the top-level bus pins.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp and per-beat data
BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
NUM_BEATS, 8, response beats per fill (512-bit line / 64)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with BUS_FILL_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  2  per-port request; held with addr/tag stable until req_grant
req_addr0 / req_addr1  in  64 each  fill address per port
req_tag0 / req_tag1  in  BUS_TAG_WIDTH each  bus tag per port (e.g. {SYSBUS_READ,SYSBUS_MEMORY,8'h00})
req_grant  out  2  one-cycle pulse: port's request accepted by bus
resp_valid  out  2  beat valid for port
resp_data  out  BUS_DATA_WIDTH  beat data (shared, qualified by resp_valid)
resp_last  out  1  final beat of burst
busy  out  1  transaction in flight
bus_reqcyc  out  1
bus_req  out  BUS_DATA_WIDTH
bus_reqtag  out  BUS_TAG_WIDTH
bus_reqack  in  1
bus_respcyc  in  1
bus_respack  out  1
bus_resp  in  BUS_DATA_WIDTH
bus_resptag  in  BUS_TAG_WIDTH
timeout_err  out  1  (present only with macro; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. On reset all outputs are 0, state is IDLE, beat_cnt is 0, rr_ptr is 0 (port 0 favoured).
- FSM: IDLE, REQ, WAIT_RESP, BURST.
- IDLE: if any req_valid is set, pick the owner by round-robin.
  - If both ports request, the port != last owner wins; rr_ptr says port 0 first after reset.
  - Latch owner, addr and tag into registers; go to REQ next cycle.
  - No request: stay in IDLE.
- REQ:
  - bus_reqcyc=1; bus_req and bus_reqtag come from the latched registers and are stable until acked.
  - On bus_reqack: req_grant[owner] pulses for that cycle, state goes to WAIT_RESP, bus_reqcyc drops the next cycle.
  - Arbitration is frozen here; a new req_valid on the other port waits.
- WAIT_RESP / BURST:
  - Combinational outputs: bus_respack=bus_respcyc; resp_valid[owner]=bus_respcyc; resp_data=bus_resp.
  - Each bus_respcyc cycle is one beat and increments the 3-bit beat_cnt (log2 NUM_BEATS). The first beat moves WAIT_RESP to BURST.
  - Gaps (bus_respcyc=0) inside the burst are allowed; they produce no beat and no count.
  - resp_last=1 on the beat where beat_cnt==NUM_BEATS-1.
  - After that beat: beat_cnt wraps to 0, rr_ptr=~owner, state goes to IDLE.
- busy=1 in every state except IDLE.
- Back-to-back: the other port's pending request can enter REQ the cycle after return to IDLE. There is a minimum of one IDLE cycle between transactions.
- bus_respcyc while in IDLE or REQ: ignored. bus_respack=0 and no resp_valid.
- bus_resptag is not used for routing; the owner register alone steers beats.
- req_valid dropped before grant: a protocol violation. The arbiter still completes the latched transaction.
- Reset mid-burst: immediate abort, all outputs 0. The requester must treat the fill as lost.

Optional Feature:
BUS_FILL_ARB_TIMEOUT_EN:
- Defined: a cycle counter runs in REQ/WAIT_RESP/BURST and is cleared on each ack or beat. When it reaches TIMEOUT_CYCLES:
  - timeout_err pulses 1 cycle.
  - resp_valid/resp_last pulse for the owner with resp_data=0.
  - State goes to IDLE and rr_ptr advances.
- Undefined: no counter; timeout_err is constant 0; the FSM waits indefinitely.

Decomposition:
- Package bus_fill_pkg: the state enum, NUM_PORTS=2, PORT_IFETCH=0, PORT_DCACHE=1, and the SYSBUS tag field constants.
- One natural sub-module, rr_arbiter2: 2-input round-robin pick. Inputs req[1:0] and last-owner; outputs gnt_idx and gnt_any.

Test Plan:
1. Reset, then req_valid=01, addr0=0x1000, tag0=0x1100, bus_reqack after 3 cycles, 8 consecutive beats 0..7:
   - bus_req=0x1000 held until ack; req_grant=01 for one cycle.
   - resp_valid[0] on 8 beats; resp_last on beat 7; busy falls next cycle.
2. req_valid=11 simultaneously after reset -> port 0 is served first, then port 1 starts REQ exactly 1 IDLE cycle later. A third request from both ports -> port 0 again (alternation).
3. Burst with bus_respcyc gaps (pattern 1,0,1,1,0,0,1,1,1,1,1) -> exactly 8 beats forwarded, resp_last on the 8th; no resp_valid during gaps.
4. Assert reset at beat 4 of a port 1 fill -> all outputs 0 the same cycle (async). After release, req_valid=10 is granted normally with beat_cnt starting from 0.
5. bus_respcyc=1 while in REQ (no ack yet) -> bus_respack=0 and resp_valid=00; state stays REQ.
6. With BUS_FILL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no response after ack:
   - timeout_err is asserted 16 cycles after the ack.
   - resp_last is pulsed to the owner; arbiter returns to IDLE and accepts the next request.

Source files
------------

// File: rtl/bus_fill_pkg.sv
// Shared types and constants for the system-bus fill arbiter.
// Tag fields encode {op[2:0], space[1:0], id[7:0]} on a 13-bit bus tag.
package bus_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_BURST     = 2'd3
    } state_t;

    localparam int NUM_PORTS = 2;
    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

    localparam logic [2:0] SYSBUS_READ   = 3'b100;
    localparam logic [2:0] SYSBUS_WRITE  = 3'b101;
    localparam logic [1:0] SYSBUS_MEMORY = 2'b01;
    localparam logic [1:0] SYSBUS_IO     = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: on a tie the port that did not own
// the bus last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_idx,
    output logic       gnt_any
);

    always_comb begin
        gnt_any = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_owner;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_fill_arbiter.sv
// Shares one system-bus request/response channel between ifetch and dcache fills.
// Optional watchdog enabled by defining BUS_FILL_ARB_TIMEOUT_EN.
module bus_fill_arbiter
    import bus_fill_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_BEATS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [63:0]               req_addr0,
    input  logic [63:0]               req_addr1,
    input  logic [BUS_TAG_WIDTH-1:0]  req_tag0,
    input  logic [BUS_TAG_WIDTH-1:0]  req_tag1,
    output logic [NUM_PORTS-1:0]      req_grant,
    output logic [NUM_PORTS-1:0]      resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] resp_data,
    output logic                      resp_last,
    output logic                      busy,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      timeout_err
);

    localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

    state_t                     state, state_nxt;
    logic                       owner_q;
    logic [63:0]                addr_q;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;
    logic [BW-1:0]              beat_cnt;
    logic                       rr_ptr;
    logic                       gnt_idx, gnt_any;
    logic                       in_resp, ack, beat, last_beat, tmo, done;

    // Routing relies on owner_q alone, so the response tag is not inspected.
    logic unused_tag;
    assign unused_tag = ^bus_resptag;

    rr_arbiter2 u_rr (
        .req        (req_valid),
        .last_owner (~rr_ptr),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign in_resp   = (state == ST_WAIT_RESP) || (state == ST_BURST);
    assign ack       = (state == ST_REQ) && bus_reqack;
    assign beat      = in_resp && bus_respcyc;
    assign last_beat = beat && (beat_cnt == LAST_BEAT);
    assign done      = last_beat || tmo;

`ifdef BUS_FILL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == ST_IDLE || ack || beat || tmo)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo = (state != ST_IDLE) && !ack && !beat
              && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (done) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:      if (gnt_any) state_nxt = ST_REQ;
                ST_REQ:       if (bus_reqack) state_nxt = ST_WAIT_RESP;
                ST_WAIT_RESP: if (beat) state_nxt = ST_BURST;
                ST_BURST:     state_nxt = ST_BURST;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= PORT_IFETCH;
            addr_q   <= '0;
            tag_q    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= PORT_IFETCH;
        end else begin
            if (state == ST_IDLE && gnt_any) begin
                owner_q <= gnt_idx;
                addr_q  <= gnt_idx ? req_addr1 : req_addr0;
                tag_q   <= gnt_idx ? req_tag1 : req_tag0;
            end
            if (done) begin
                beat_cnt <= '0;
                rr_ptr   <= ~owner_q;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        req_grant   = '0;
        resp_valid  = '0;
        resp_data   = '0;
        resp_last   = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        timeout_err = tmo;
        busy        = (state != ST_IDLE);
        if (state == ST_REQ) begin
            bus_reqcyc = 1'b1;
            bus_req    = BUS_DATA_WIDTH'(addr_q);
            bus_reqtag = tag_q;
            req_grant[owner_q] = bus_reqack;
        end
        if (in_resp) begin
            bus_respack         = bus_respcyc;
            resp_valid[owner_q] = bus_respcyc;
            resp_data           = bus_resp;
            resp_last           = last_beat;
        end
        // Watchdog expiry closes the fill toward the owner with an empty beat.
        if (tmo) begin
            resp_valid[owner_q] = 1'b1;
            resp_last           = 1'b1;
            resp_data           = '0;
        end
    end

endmodule

// File: tb/tb_bus_fill_arbiter.sv
// Directed self-checking bench for bus_fill_arbiter.
// Watchdog section runs only when BUS_FILL_ARB_TIMEOUT_EN is defined.
module tb_bus_fill_arbiter;
    import bus_fill_pkg::*;

    localparam int DW = 64;
    localparam int TGW = 13;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [63:0]    req_addr0, req_addr1;
    logic [TGW-1:0] req_tag0, req_tag1;
    logic [1:0]     req_grant, resp_valid;
    logic [DW-1:0]  resp_data;
    logic           resp_last, busy;
    logic           bus_reqcyc;
    logic [DW-1:0]  bus_req;
    logic [TGW-1:0] bus_reqtag;
    logic           bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0]  bus_resp;
    logic [TGW-1:0] bus_resptag;
    logic           timeout_err;

    int nchk = 0;
    int nerr = 0;

    bus_fill_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TGW),
        .NUM_BEATS      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_tag0    (req_tag0),
        .req_tag1    (req_tag1),
        .req_grant   (req_grant),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_last   (resp_last),
        .busy        (busy),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_reqcyc"}, bus_reqcyc, 0);
        chk({tag, "_req"}, bus_req, 0);
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_rdata"}, resp_data, 0);
        chk({tag, "_rlast"}, resp_last, 0);
        chk({tag, "_respack"}, bus_respack, 0);
        chk({tag, "_grant"}, req_grant, 0);
    endtask

    // Drive n consecutive beats; resp_last expected only on the 8th.
    task automatic run_beats(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'hB000 + 64'(i);
            #1;
            chk("beat_valid", resp_valid, v);
            chk("beat_data", resp_data, 64'hB000 + 64'(i));
            chk("beat_last", resp_last, (i == 7));
            chk("beat_ack", bus_respack, 1);
            step();
        end
        bus_respcyc = 1'b0;
    endtask

    // From IDLE with req_valid set: enter REQ, check address, ack at once.
    task automatic grant_now(input logic [63:0] addr, input logic [1:0] g);
        step();
        chk("req_cyc", bus_reqcyc, 1);
        chk("req_addr", bus_req, addr);
        bus_reqack = 1'b1;
        #1;
        chk("req_grant", req_grant, g);
        step();
        bus_reqack = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("wait_cyc_drop", bus_reqcyc, 0);
        chk("wait_busy", busy, 1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        req_tag0 = '0;
        req_tag1 = '0;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        bus_resptag = '0;
        #12;
        chk_quiet("reset");
        chk("reset_tmo", timeout_err, 0);
        step();
        reset = 1'b0;

        // 1: single port-0 fill, ack on third REQ cycle
        req_valid = 2'b01;
        req_addr0 = 64'h1000;
        req_tag0 = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};
        #1;
        chk("t1_idle_busy", busy, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_reqcyc", bus_reqcyc, 1);
            chk("t1_req", bus_req, 64'h1000);
            chk("t1_tag", bus_reqtag, 13'h1100);
            chk("t1_nogrant", req_grant, 0);
            step();
        end
        bus_reqack = 1'b1;
        #1;
        chk("t1_req_ack", bus_req, 64'h1000);
        chk("t1_grant", req_grant, 2'b01);
        step();
        bus_reqack = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("t1_reqcyc_drop", bus_reqcyc, 0);
        chk("t1_grant_pulse", req_grant, 0);
        run_beats(2'b01, 8);
        #1;
        chk("t1_busy_fall", busy, 0);

        // 2 + 5: tie after reset, alternation, respcyc ignored in REQ
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 2'b11;
        req_addr0 = 64'h2000;
        req_addr1 = 64'h3000;
        req_tag1 = {SYSBUS_READ, SYSBUS_MEMORY, 8'h01};
        grant_now(64'h2000, 2'b01);
        req_valid = 2'b10;
        run_beats(2'b01, 8);
        #1;
        chk("t2_gap_idle", busy, 0);
        chk("t2_gap_reqcyc", bus_reqcyc, 0);
        step();
        chk("t2_p1_reqcyc", bus_reqcyc, 1);
        chk("t2_p1_req", bus_req, 64'h3000);
        chk("t2_p1_tag", bus_reqtag, 13'h1101);
        bus_reqack = 1'b1;
        #1;
        chk("t2_p1_grant", req_grant, 2'b10);
        step();
        bus_reqack = 1'b0;
        req_valid = 2'b00;
        run_beats(2'b10, 8);
        req_valid = 2'b11;
        req_addr0 = 64'h4000;
        step();
        chk("t2_alt_req", bus_req, 64'h4000);
        bus_respcyc = 1'b1;
        #1;
        chk("t5_respack", bus_respack, 0);
        chk("t5_rv", resp_valid, 0);
        step();
        chk("t5_still_req", bus_reqcyc, 1);
        bus_respcyc = 1'b0;
        bus_reqack = 1'b1;
        #1;
        chk("t2_alt_grant", req_grant, 2'b01);
        step();
        bus_reqack = 1'b0;
        req_valid = 2'b00;
        run_beats(2'b01, 8);

        // 3: burst with gaps
        req_valid = 2'b10;
        req_addr1 = 64'h5000;
        grant_now(64'h5000, 2'b10);
        begin
            logic [10:0] pat;
            int nb;
            pat = 11'b11111001101;
            nb = 0;
            for (int i = 0; i < 11; i++) begin
                bus_respcyc = pat[i];
                bus_resp = 64'hC0 + 64'(i);
                #1;
                chk("t3_rv", resp_valid, pat[i] ? 2'b10 : 2'b00);
                chk("t3_last", resp_last, pat[i] && (nb == 7));
                if (pat[i]) nb++;
                step();
            end
            bus_respcyc = 1'b0;
            #1;
            chk("t3_done", busy, 0);
        end

        // 4: async reset at beat 4 of a port-1 fill
        req_valid = 2'b10;
        req_addr1 = 64'h6000;
        grant_now(64'h6000, 2'b10);
        run_beats(2'b10, 4);
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD;
        reset = 1'b1;
        #1;
        chk_quiet("t4_abort");
        step();
        reset = 1'b0;
        bus_respcyc = 1'b0;
        req_valid = 2'b10;
        grant_now(64'h6000, 2'b10);
        run_beats(2'b10, 8);
        #1;
        chk("t4_tmo_off", timeout_err, 0);

`ifdef BUS_FILL_ARB_TIMEOUT_EN
        // 6: watchdog after ack with no response
        req_valid = 2'b01;
        req_addr0 = 64'h7000;
        grant_now(64'h7000, 2'b01);
        for (int k = 1; k < 16; k++) begin
            chk("t6_no_tmo", timeout_err, 0);
            step();
        end
        chk("t6_tmo", timeout_err, 1);
        chk("t6_rv", resp_valid, 2'b01);
        chk("t6_last", resp_last, 1);
        chk("t6_data", resp_data, 0);
        step();
        chk("t6_idle", busy, 0);
        chk("t6_tmo_pulse", timeout_err, 0);
        req_valid = 2'b10;
        req_addr1 = 64'h8000;
        step();
        chk("t6_next_req", bus_req, 64'h8000);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
